mc6809_dma_arbiter: RTL and testbench
=====================================

Name: mc6809_dma_arbiter

Overview:
- Shares the 6809 bus between the CPU core and up to N_REQ DMA masters (video fetch, disk DMA) using the core's nDMABREQ input and its BA/BS outputs.
- Requests the bus, waits for the CPU to float it, then grants one master round-robin for a bounded burst.
- Releases the bus and enforces a CPU holdoff so the core is never starved.
- Sits beside the core and shares CLK_ROOT/CE_E_FALL with it. Every state change happens on an E-fall enable.

Parameters:
- N_REQ, 2, number of DMA requesters (1..8).
- MAX_BURST, 14, maximum granted E cycles per burst (1..14; the core steals the bus back after 15).
- HOLDOFF, 2, minimum E cycles nDMABREQ stays high after a release (0..15).

Ports:
- CLK_ROOT  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- CE_E_FALL  in  1  one-CLK_ROOT-wide enable marking the E falling edge; qualifies all state updates.
- BA  in  1  bus available from core.
- BS  in  1  bus status from core.
- REQ  in  N_REQ  per-master bus request, level, held until burst done.
- GNT  out  N_REQ  one-hot grant; master may drive ADDR/D/RnW while its bit is high.
- nDMABREQ  out  1  to core, active-low DMA/bus request.
- DMA_ACTIVE  out  1  high while any GNT bit is high.
- BURST_END  out  1  one CE_E_FALL-aligned CLK_ROOT pulse when a grant ends.

Behaviour:
- Reset (async, immediate) sets the following: state=IDLE, nDMABREQ=1, GNT=0, DMA_ACTIVE=0, BURST_END=0, rr pointer=0, burst counter=0, holdoff counter=0.
- All registers update only on CLK_ROOT edges with CE_E_FALL=1. BURST_END is the exception: it clears on the next CLK_ROOT edge.

State machine:
- IDLE: if holdoff counter=0 and |REQ, go to ASK and drive nDMABREQ=0. Otherwise decrement holdoff counter if it is nonzero.
- ASK: hold nDMABREQ=0. When sampled BA=1 and BS=1, go to GRANT.
  - Select the winner as the first REQ bit at or above the rr pointer, wrapping modulo N_REQ.
  - Set the winner's GNT bit and load burst counter=1.
  - If REQ drops to 0 while in ASK, go to RELEASE with no grant and no BURST_END pulse.
- GRANT: GNT is stable. At each E fall:
  - If the winner's REQ=0, or burst counter=MAX_BURST, or BA=0 (core reclaimed the bus), go to RELEASE.
  - Otherwise increment the burst counter.
- RELEASE: entered with GNT=0, nDMABREQ=1, BURST_END pulse (only when a grant existed), rr pointer=winner+1 mod N_REQ, holdoff counter=HOLDOFF. Wait for BA=0, then go to IDLE.

Timing and boundary rules:
- GNT deasserts on the same E fall as nDMABREQ deasserts; no overlap with the CPU.
- Maximum grant length is MAX_BURST E cycles, counted from the first E fall with GNT high.
- Only one GNT bit may ever be high. Changes to REQ bits other than the winner's during GRANT are ignored.
- If REQ of the winner drops in the same E fall as burst counter=MAX_BURST, a single release occurs.
- If BA=0 in GRANT, this is treated as an abort: normal release, BURST_END pulses.
- With HOLDOFF=0, re-request may occur on the E fall after the return to IDLE.
- Reset mid-burst: GNT drops asynchronously and nDMABREQ goes high immediately.

Test Plan:
- Single master: REQ=01, core model asserts BA=BS=1 two E cycles after nDMABREQ falls.
  - Required: GNT=01 on that E fall.
  - Required: REQ held causes release after exactly 14 E cycles with one BURST_END pulse.
  - Required: nDMABREQ stays high ≥2 E cycles.
- Early drop: REQ[0] falls after 3 granted E cycles.
  - Required: GNT=00 and nDMABREQ=1 on the next E fall, BURST_END pulses once.
- Round-robin: REQ=11 held continuously.
  - Required: grants alternate 01,10,01,10 across four bursts, each separated by the HOLDOFF gap.
- Abort: core drops BA during GRANT at burst count 5.
  - Required: GNT clears on that E fall, BURST_END pulses, rr pointer advances.
- Withdraw in ASK: REQ goes 01→00 before BA=BS=1.
  - Required: no GNT ever high, no BURST_END, return to IDLE after BA=0.
- Reset mid-burst: assert RESET asynchronously between E falls while GNT=10.
  - Required: GNT=00 and nDMABREQ=1 without waiting for CLK_ROOT.
  - Required: after release, the first grant goes to REQ[0] (rr pointer back to 0).

Source files
------------

// File: rtl/mc6809_dma_arbiter.sv
// Shares the 6809 bus between the CPU core and N_REQ DMA masters via nDMABREQ/BA/BS.
// Round-robin grants of bounded bursts, with a CPU holdoff after each release.
module mc6809_dma_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 14,
    parameter int HOLDOFF   = 2
) (
    input  logic             CLK_ROOT,
    input  logic             RESET,
    input  logic             CE_E_FALL,
    input  logic             BA,
    input  logic             BS,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic             nDMABREQ,
    output logic             DMA_ACTIVE,
    output logic             BURST_END
);
    // state     | meaning
    // S_IDLE    | CPU owns the bus; holdoff counter runs down
    // S_ASK     | nDMABREQ low, waiting for the core to float the bus (BA=BS=1)
    // S_GRANT   | one master owns the bus for a bounded burst
    // S_RELEASE | nDMABREQ high, waiting for the core to take the bus back (BA=0)

    localparam int         IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] MAX4  = 4'(MAX_BURST);
    localparam logic [3:0] HOLD4 = 4'(HOLDOFF);

    typedef enum logic [1:0] {S_IDLE, S_ASK, S_GRANT, S_RELEASE} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt, gnt_nxt;
    logic             ndma, ndma_nxt;
    logic             burst_end, burst_end_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] win_idx, win_idx_nxt;
    logic [IDX_W-1:0] sel_idx, rr_after_win;
    logic [3:0]       burst_cnt, burst_cnt_nxt;
    logic [3:0]       hold_cnt, hold_cnt_nxt;
    logic             sel_found;

    // Scan downward so the request closest to rr_ptr (modulo N_REQ) wins last.
    always_comb begin : pick
        int idx;
        idx       = 0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (REQ[IDX_W'(idx)]) begin
                sel_idx   = IDX_W'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign rr_after_win = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        ndma_nxt      = ndma;
        burst_end_nxt = 1'b0;
        rr_ptr_nxt    = rr_ptr;
        win_idx_nxt   = win_idx;
        burst_cnt_nxt = burst_cnt;
        hold_cnt_nxt  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (hold_cnt == 4'd0 && sel_found) begin
                    state_nxt = S_ASK;
                    ndma_nxt  = 1'b0;
                end else if (hold_cnt != 4'd0) begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
            S_ASK: begin
                if (!sel_found) begin
                    state_nxt    = S_RELEASE;
                    ndma_nxt     = 1'b1;
                    hold_cnt_nxt = HOLD4;
                end else if (BA && BS) begin
                    state_nxt         = S_GRANT;
                    gnt_nxt           = '0;
                    gnt_nxt[sel_idx]  = 1'b1;
                    win_idx_nxt       = sel_idx;
                    burst_cnt_nxt     = 4'd1;
                end
            end
            S_GRANT: begin
                // Winner drop, burst limit and core abort all collapse into one release.
                if (!REQ[win_idx] || burst_cnt == MAX4 || !BA) begin
                    state_nxt     = S_RELEASE;
                    gnt_nxt       = '0;
                    ndma_nxt      = 1'b1;
                    burst_end_nxt = 1'b1;
                    rr_ptr_nxt    = rr_after_win;
                    hold_cnt_nxt  = HOLD4;
                end else begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end
            end
            S_RELEASE: begin
                if (!BA) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_ROOT or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            gnt       <= '0;
            ndma      <= 1'b1;
            burst_end <= 1'b0;
            rr_ptr    <= '0;
            win_idx   <= '0;
            burst_cnt <= 4'd0;
            hold_cnt  <= 4'd0;
        end else if (CE_E_FALL) begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            ndma      <= ndma_nxt;
            burst_end <= burst_end_nxt;
            rr_ptr    <= rr_ptr_nxt;
            win_idx   <= win_idx_nxt;
            burst_cnt <= burst_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end else begin
            burst_end <= 1'b0;
        end
    end

    assign GNT        = gnt;
    assign nDMABREQ   = ndma;
    assign DMA_ACTIVE = |gnt;
    assign BURST_END  = burst_end;

endmodule

// File: tb/tb_mc6809_dma_arbiter.sv
// Bench for mc6809_dma_arbiter: directed scenarios plus random traffic against a
// rule-level reference model of the bus handover and round-robin arbitration.
module tb_mc6809_dma_arbiter;
    localparam int N_REQ     = 2;
    localparam int MAX_BURST = 14;
    localparam int HOLDOFF   = 2;

    logic             CLK_ROOT  = 1'b0;
    logic             RESET     = 1'b1;
    logic             CE_E_FALL = 1'b0;
    logic             BA        = 1'b0;
    logic             BS        = 1'b0;
    logic [N_REQ-1:0] REQ       = '0;
    logic [N_REQ-1:0] GNT;
    logic             nDMABREQ;
    logic             DMA_ACTIVE;
    logic             BURST_END;

    int n_checks = 0;
    int n_errors = 0;

    mc6809_dma_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_BURST(MAX_BURST),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .CLK_ROOT  (CLK_ROOT),
        .RESET     (RESET),
        .CE_E_FALL (CE_E_FALL),
        .BA        (BA),
        .BS        (BS),
        .REQ       (REQ),
        .GNT       (GNT),
        .nDMABREQ  (nDMABREQ),
        .DMA_ACTIVE(DMA_ACTIVE),
        .BURST_END (BURST_END)
    );

    always #5 CLK_ROOT = ~CLK_ROOT;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether the core has been asked, and
    // whether a release is still waiting for the core to take BA back.
    int m_owner, m_len, m_hold, m_rr;
    bit m_asking, m_wait_ba;
    int exp_gnt;
    bit exp_ndma, exp_be;

    task automatic model_reset();
        m_owner = -1; m_len = 0; m_hold = 0; m_rr = 0;
        m_asking = 0; m_wait_ba = 0;
        exp_gnt = 0; exp_ndma = 1; exp_be = 0;
    endtask

    task automatic model_release();
        m_asking  = 0;
        m_wait_ba = 1;
        m_hold    = HOLDOFF;
    endtask

    task automatic model_step();
        exp_be = 0;
        if (m_wait_ba) begin
            if (!BA) m_wait_ba = 0;
        end else if (m_owner >= 0) begin
            if (!REQ[m_owner] || m_len == MAX_BURST || !BA) begin
                m_rr    = (m_owner + 1) % N_REQ;
                m_owner = -1;
                exp_be  = 1;
                model_release();
            end else begin
                m_len++;
            end
        end else if (m_asking) begin
            if (REQ == 0) model_release();
            else if (BA && BS) begin
                for (int k = 0; k < N_REQ; k++) begin
                    int c;
                    c = (m_rr + k) % N_REQ;
                    if (m_owner < 0 && REQ[c]) m_owner = c;
                end
                m_len = 1;
            end
        end else if (m_hold == 0 && REQ != 0) begin
            m_asking = 1;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        exp_gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
        exp_ndma = !m_asking;
    endtask

    // Core stand-in: floats the bus core_delay E cycles after nDMABREQ falls,
    // optionally reclaims it once the burst reaches abort_at.
    int core_wait, core_delay, abort_at;
    bit core_abort;

    task automatic core_update();
        if (exp_ndma) begin
            BA = 0; BS = 0; core_wait = 0; core_abort = 0;
        end else begin
            core_wait++;
            if (m_owner >= 0 && abort_at > 0 && m_len == abort_at) begin
                core_abort = 1;
                abort_at   = 0;
            end
            if (core_abort) begin
                BA = 0; BS = 0;
            end else if (core_wait >= core_delay) begin
                BA = 1; BS = 1;
            end
        end
    endtask

    // Observed-bus monitor: burst lengths, grant order, nDMABREQ-high gaps.
    int step_no, cur_len, hi_run, be_total, t_ndma_fall, t_gnt_rise;
    logic [N_REQ-1:0] prev_gnt;
    logic prev_ndma;
    int len_q[$];
    int gnt_q[$];
    int gap_q[$];

    task automatic clear_mon();
        len_q.delete(); gnt_q.delete(); gap_q.delete();
        cur_len = 0; hi_run = 0; be_total = 0;
    endtask

    task automatic monitor();
        if (GNT != 0 && prev_gnt == 0) begin
            gnt_q.push_back(int'(GNT));
            t_gnt_rise = step_no;
        end
        if (GNT != 0) cur_len++;
        else if (prev_gnt != 0) begin
            len_q.push_back(cur_len);
            cur_len = 0;
        end
        if (nDMABREQ) hi_run++;
        else if (prev_ndma) begin
            gap_q.push_back(hi_run);
            hi_run      = 0;
            t_ndma_fall = step_no;
        end
        be_total += int'(BURST_END);
        prev_gnt  = GNT;
        prev_ndma = nDMABREQ;
    endtask

    // One E period = four CLK_ROOT cycles, enable on the first.
    task automatic e_step();
        @(negedge CLK_ROOT);
        CE_E_FALL = 1;
        model_step();
        @(negedge CLK_ROOT);
        CE_E_FALL = 0;
        check_val("gnt", int'(GNT), exp_gnt);
        check_val("ndmabreq", int'(nDMABREQ), int'(exp_ndma));
        check_val("burst_end", int'(BURST_END), int'(exp_be));
        check_val("dma_active", int'(DMA_ACTIVE), int'(exp_gnt != 0));
        monitor();
        @(negedge CLK_ROOT);
        check_val("burst_end_clear", int'(BURST_END), 0);
        @(negedge CLK_ROOT);
        step_no++;
        core_update();
    endtask

    task automatic apply_reset();
        RESET = 1; BA = 0; BS = 0; CE_E_FALL = 0;
        repeat (2) @(negedge CLK_ROOT);
        model_reset();
        core_wait = 0; core_delay = 2; abort_at = 0; core_abort = 0;
        prev_gnt = '0; prev_ndma = 1'b1;
        clear_mon();
        check_val("rst_gnt", int'(GNT), 0);
        check_val("rst_ndmabreq", int'(nDMABREQ), 1);
        check_val("rst_burst_end", int'(BURST_END), 0);
        check_val("rst_dma_active", int'(DMA_ACTIVE), 0);
        RESET = 0;
    endtask

    task automatic run_until_bursts(input int n, input int bound);
        int s;
        s = 0;
        while (len_q.size() < n && s < bound) begin e_step(); s++; end
        check_val("bursts_reached", len_q.size(), n);
    endtask

    task automatic run_until_grants(input int n, input int bound);
        int s;
        s = 0;
        while (gnt_q.size() < n && s < bound) begin e_step(); s++; end
        check_val("grants_reached", gnt_q.size(), n);
    endtask

    initial begin
        int exp_rr[4];
        int s;
        exp_rr[0] = 1; exp_rr[1] = 2; exp_rr[2] = 1; exp_rr[3] = 2;
        step_no = 0; t_ndma_fall = 0; t_gnt_rise = 0;

        // Single master: full-length burst, grant latency, holdoff gap
        apply_reset();
        REQ = 2'b01;
        run_until_bursts(1, 100);
        check_val("t1_len", len_q[0], MAX_BURST);
        check_val("t1_gnt", gnt_q[0], 1);
        check_val("t1_latency", t_gnt_rise - t_ndma_fall, 2);
        check_val("t1_be_count", be_total, 1);
        s = 0;
        while (gap_q.size() < 2 && s < 30) begin e_step(); s++; end
        check_val("t1_gap_seen", gap_q.size(), 2);
        check_val("t1_gap", gap_q[1], HOLDOFF + 2);

        // Early drop after three granted E cycles
        apply_reset();
        REQ = 2'b01;
        s = 0;
        while (cur_len < 3 && s < 20) begin e_step(); s++; end
        REQ = 2'b00;
        e_step();
        check_val("t2_gnt", int'(GNT), 0);
        check_val("t2_ndmabreq", int'(nDMABREQ), 1);
        check_val("t2_len", len_q[0], 3);
        repeat (4) e_step();
        check_val("t2_be_count", be_total, 1);

        // Round-robin with both masters held
        apply_reset();
        REQ = 2'b11;
        run_until_bursts(4, 200);
        for (int i = 0; i < 4; i++) check_val("t3_rr_order", gnt_q[i], exp_rr[i]);
        for (int i = 1; i < 4; i++) check_val("t3_gap", gap_q[i], HOLDOFF + 2);

        // Core abort at burst count 5
        apply_reset();
        REQ = 2'b11;
        abort_at = 5;
        run_until_bursts(2, 200);
        check_val("t4_len", len_q[0], 5);
        check_val("t4_first", gnt_q[0], 1);
        check_val("t4_next", gnt_q[1], 2);
        check_val("t4_be_count", be_total, 2);

        // Withdraw while asking
        apply_reset();
        REQ = 2'b01;
        e_step();
        REQ = 2'b00;
        repeat (10) e_step();
        check_val("t5_no_grant", gnt_q.size(), 0);
        check_val("t5_no_be", be_total, 0);
        check_val("t5_ndmabreq", int'(nDMABREQ), 1);

        // Asynchronous reset while master 1 owns the bus
        apply_reset();
        REQ = 2'b11;
        s = 0;
        while (!(GNT == 2'b10 && cur_len >= 3) && s < 200) begin e_step(); s++; end
        check_val("t6_reached_gnt10", int'(GNT), 2);
        #3;
        RESET = 1;
        #1;
        check_val("t6_async_gnt", int'(GNT), 0);
        check_val("t6_async_ndmabreq", int'(nDMABREQ), 1);
        check_val("t6_async_active", int'(DMA_ACTIVE), 0);
        apply_reset();
        run_until_grants(1, 50);
        check_val("t6_first_after_reset", gnt_q[0], 1);

        // Random traffic
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) REQ = N_REQ'($urandom_range(0, 3));
            if (exp_ndma) begin
                core_delay = $urandom_range(1, 4);
                abort_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_BURST) : 0;
            end
            e_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
